piso_shift_reg: RTL and testbench

//   Parallel-in / serial-out shift register. It transmits one WIDTH-bit word as

---
 rtl/piso_shift_reg.sv | 74 +++++++
 tb/tb_piso_shift_reg.sv | 106 ++++++++++
 2 files changed

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register: sends one WIDTH-bit word as WIDTH
// single-bit beats over a valid/ready serial link.
module piso_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] I,
   input  logic             I_valid,
   output logic             I_ready,
   output logic             O,
   output logic             O_valid,
   input  logic             O_ready,
   output logic             O_last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;

   logic in_shift, at_last, accept, xfer;

   assign in_shift = (state_q == SHIFT);
   assign at_last  = in_shift && (cnt_q == CNT_LAST);
   assign xfer     = in_shift && O_ready;
   assign accept   = I_valid && I_ready;

   always_comb begin
      I_ready = !in_shift || (at_last && O_ready);
      O_valid = in_shift;
      O_last  = at_last;
      O       = 1'b0;
      if (in_shift) O = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
   end

   // A new word may be loaded on the same edge as the last beat leaves,
   // so accept takes priority over the return to IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      if (accept) begin
         state_d = SHIFT;
         cnt_d   = '0;
         shreg_d = I;
      end else if (xfer) begin
         if (at_last) begin
            state_d = IDLE;
         end else begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
      end
   end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: three instances (LSB-first, MSB-first, WIDTH=1)
// compared every cycle against a word/beat-index reference model.
module tb_piso_shift_reg;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       RESET = 1'b1, I_valid = 1'b0, O_ready = 1'b0;
   logic [7:0] I8 = '0;
   logic       I1 = 1'b0;
   logic [2:0] ir, o, ov, ol;

   piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .CLK(CLK), .RESET(RESET), .I(I8), .I_valid(I_valid), .I_ready(ir[0]),
      .O(o[0]), .O_valid(ov[0]), .O_ready(O_ready), .O_last(ol[0]));
   piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .CLK(CLK), .RESET(RESET), .I(I8), .I_valid(I_valid), .I_ready(ir[1]),
      .O(o[1]), .O_valid(ov[1]), .O_ready(O_ready), .O_last(ol[1]));
   piso_shift_reg #(.WIDTH(1), .MSB_FIRST(1'b0)) u_w1 (
      .CLK(CLK), .RESET(RESET), .I(I1), .I_valid(I_valid), .I_ready(ir[2]),
      .O(o[2]), .O_valid(ov[2]), .O_ready(O_ready), .O_last(ol[2]));

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model: a word in flight plus the index of the beat on the wire.
   int wd[3]  = '{8, 8, 1};
   int msb[3] = '{0, 1, 0};
   bit busy[3];
   int word[3];
   int idx[3];

   task automatic step(input bit rst, input bit iv, input bit ordy,
                       input logic [7:0] d8, input bit d1, input bit check = 1'b1);
      @(negedge CLK);
      RESET = rst; I_valid = iv; O_ready = ordy; I8 = d8; I1 = d1;
      #1;
      for (int k = 0; k < 3; k++) begin
         int  pos, din;
         bit  e_o, e_l, e_ir;
         pos  = msb[k] ? (wd[k] - 1 - idx[k]) : idx[k];
         e_o  = busy[k] ? word[k][pos] : 1'b0;
         e_l  = busy[k] && (idx[k] == wd[k] - 1);
         e_ir = !busy[k] || (e_l && ordy);
         if (check) begin
            chk($sformatf("u%0d.O_valid", k), ov[k], busy[k]);
            chk($sformatf("u%0d.O", k),       o[k],  e_o);
            chk($sformatf("u%0d.O_last", k),  ol[k], e_l);
            chk($sformatf("u%0d.I_ready", k), ir[k], e_ir);
         end
         din = (k == 2) ? d1 : d8;
         if (rst) begin
            busy[k] = 1'b0; idx[k] = 0;
         end else if (iv && e_ir) begin
            busy[k] = 1'b1; word[k] = din; idx[k] = 0;
         end else if (busy[k] && ordy) begin
            if (e_l) busy[k] = 1'b0;
            else     idx[k]++;
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin busy[k] = 1'b0; word[k] = 0; idx[k] = 0; end
      // Reset with I_valid high: nothing may load.
      step(1, 1, 1, 8'hC1, 1'b1, 1'b0);
      step(1, 1, 1, 8'hC1, 1'b1);
      step(0, 0, 1, 8'hC1, 1'b1);
      // Single word, consumer always ready.
      step(0, 1, 1, 8'hC1, 1'b1);
      for (int c = 0; c < 10; c++) step(0, 0, 1, 8'h00, 1'b0);
      // Backpressure for 3 cycles after beat 2.
      step(0, 1, 1, 8'hC1, 1'b1);
      step(0, 0, 1, 8'h00, 1'b0);
      step(0, 0, 1, 8'h00, 1'b0);
      for (int c = 0; c < 3; c++) step(0, 0, 0, 8'h00, 1'b0);
      for (int c = 0; c < 9; c++) step(0, 0, 1, 8'h00, 1'b0);
      // Back-to-back words with I_valid held.
      for (int c = 0; c <= 8; c++) step(0, 1, 1, (c < 8) ? 8'hC1 : 8'h3C, 1'b1);
      for (int c = 0; c < 10; c++) step(0, 0, 1, 8'h00, 1'b0);
      // Reset mid-word, then a fresh word.
      step(0, 1, 1, 8'hC1, 1'b1);
      for (int c = 0; c < 3; c++) step(0, 0, 1, 8'h00, 1'b0);
      step(1, 0, 1, 8'h00, 1'b0);
      step(0, 0, 1, 8'h00, 1'b0);
      step(0, 1, 1, 8'h01, 1'b1);
      for (int c = 0; c < 10; c++) step(0, 0, 1, 8'h00, 1'b0);
      // Single-bit stream 1,0,1.
      step(0, 1, 1, 8'hFF, 1'b1);
      step(0, 1, 1, 8'hFF, 1'b0);
      step(0, 1, 1, 8'hFF, 1'b1);
      for (int c = 0; c < 10; c++) step(0, 0, 1, 8'h00, 1'b0);
      // Random traffic with occasional reset.
      for (int c = 0; c < 600; c++)
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
